// File: rtl/alu_port_arbiter_if.sv
// Signal bundle between the two requesters, the shared ALU and the arbiter.
// The arbiter uses the slave modport; the requester/ALU side uses master.
interface alu_port_arbiter_if;
  logic       req0;
  logic       req1;
  logic [3:0] op0;
  logic [3:0] op1;
  logic [7:0] a0;
  logic [7:0] a1;
  logic [7:0] b0;
  logic [7:0] b1;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [3:0] alu_select;
  logic       done0;
  logic       done1;
  logic [7:0] result0;
  logic [7:0] result1;
  logic       zero0;
  logic       zero1;
  logic       illegal0;
  logic       illegal1;

  modport slave (
    input  req0, req1, op0, op1, a0, a1, b0, b1, alu_result, alu_zero,
    output alu_data1, alu_data2, alu_select, done0, done1,
           result0, result1, zero0, zero1, illegal0, illegal1
  );

  modport master (
    output req0, req1, op0, op1, a0, a1, b0, b1, alu_result, alu_zero,
    input  alu_data1, alu_data2, alu_select, done0, done1,
           result0, result1, zero0, zero1, illegal0, illegal1
  );
endinterface

// File: rtl/alu_port_arbiter.sv
// Round-robin sequencer sharing one 8-bit ALU between two ports.
// Legal op: DONE at grant+LAT, occupancy LAT+2 cycles; illegal op: DONE at grant edge.
module alu_port_arbiter #(
  parameter int LAT_BASIC = 1,
  parameter int LAT_MULT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [7:0] CNT_BASIC = 8'(LAT_BASIC - 1);
  localparam logic [7:0] CNT_MULT  = 8'(LAT_MULT - 1);
  localparam logic [3:0] OP_MULT   = 4'b1000;

  logic [1:0] state;
  logic       prio;
  logic       port;
  logic [7:0] cnt;

  logic       gnt_vld;
  logic       gnt_port;
  logic [3:0] sel_op;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic       sel_illegal;

  // With both ports requesting, prio decides; otherwise the lone requester wins.
  always_comb begin
    gnt_vld     = bus.req0 | bus.req1;
    gnt_port    = (bus.req0 & bus.req1) ? prio : bus.req1;
    sel_op      = gnt_port ? bus.op1 : bus.op0;
    sel_a       = gnt_port ? bus.a1  : bus.a0;
    sel_b       = gnt_port ? bus.b1  : bus.b0;
    sel_illegal = sel_op[3] & (sel_op[2:0] != 3'b000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      prio           <= 1'b0;
      port           <= 1'b0;
      cnt            <= 8'd0;
      bus.alu_data1  <= 8'd0;
      bus.alu_data2  <= 8'd0;
      bus.alu_select <= 4'd0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.result0    <= 8'd0;
      bus.result1    <= 8'd0;
      bus.zero0      <= 1'b0;
      bus.zero1      <= 1'b0;
      bus.illegal0   <= 1'b0;
      bus.illegal1   <= 1'b0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            port <= gnt_port;
            prio <= ~gnt_port;
            if (sel_illegal) begin
              // Rejected ops complete at once and leave the ALU registers alone.
              if (gnt_port) begin
                bus.illegal1 <= 1'b1;
                bus.done1    <= 1'b1;
              end else begin
                bus.illegal0 <= 1'b1;
                bus.done0    <= 1'b1;
              end
              state <= RESP;
            end else begin
              bus.alu_select <= sel_op;
              bus.alu_data1  <= sel_a;
              bus.alu_data2  <= sel_b;
              cnt            <= (sel_op == OP_MULT) ? CNT_MULT : CNT_BASIC;
              state          <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            if (port) begin
              bus.result1  <= bus.alu_result;
              bus.zero1    <= bus.alu_zero;
              bus.illegal1 <= 1'b0;
              bus.done1    <= 1'b1;
            end else begin
              bus.result0  <= bus.alu_result;
              bus.zero0    <= bus.alu_zero;
              bus.illegal0 <= 1'b0;
              bus.done0    <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Directed bench for alu_port_arbiter with a behavioural ALU on the bus.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_port_arbiter;

  localparam int LAT_BASIC = 1;
  localparam int LAT_MULT  = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  alu_port_arbiter_if bus ();

  alu_port_arbiter #(.LAT_BASIC(LAT_BASIC), .LAT_MULT(LAT_MULT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU: 0 mov, 1 add, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 ror, 8 mult.
  function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [7:0] d1,
                                       input logic [7:0] d2);
    logic [15:0] p;
    p = 16'(d1) * 16'(d2);
    case (s)
      4'd0:    return d2;
      4'd1:    return d1 + d2;
      4'd2:    return d1 & d2;
      4'd3:    return d1 | d2;
      4'd4:    return d1 << d2[2:0];
      4'd5:    return d1 >> d2[2:0];
      4'd6:    return 8'($signed(d1) >>> d2[2:0]);
      4'd7:    return (d1 >> d2[2:0]) | (d1 << (4'd8 - {1'b0, d2[2:0]}));
      4'd8:    return p[7:0];
      default: return d1;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_select, bus.alu_data1, bus.alu_data2);
  assign bus.alu_zero   = (bus.alu_result == 8'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Waits up to 20 edges for the port's DONE; n = edges waited (0 on timeout).
  task automatic wait_done(input string tag, input bit p, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((p ? bus.done1 : bus.done0) === 1'b1) begin
        n = i;
        break;
      end
    end
    check({tag, "_seen"}, 32'(n != 0), 32'd1);
  endtask

  int n;
  int last_cyc;
  bit p;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.req0 = 0; bus.req1 = 0;
    bus.op0 = 0; bus.op1 = 0;
    bus.a0 = 0; bus.a1 = 0; bus.b0 = 0; bus.b1 = 0;
    do_reset();

    check("rst_sel", 32'(bus.alu_select), 32'd0);
    check("rst_res0", 32'(bus.result0), 32'd0);
    check("rst_done", 32'({bus.done0, bus.done1}), 32'd0);

    // Single add on port 0
    bus.req0 = 1; bus.op0 = 4'd1; bus.a0 = 8'd5; bus.b0 = 8'd3;
    tick();
    bus.req0 = 0;
    check("add_sel", 32'(bus.alu_select), 32'd1);
    check("add_busy_done", 32'(bus.done0), 32'd0);
    tick();
    check("add_done0", 32'(bus.done0), 32'd1);
    check("add_res0", 32'(bus.result0), 32'd8);
    check("add_zero0", 32'(bus.zero0), 32'd0);
    check("add_done1", 32'(bus.done1), 32'd0);
    tick();
    check("add_done0_pulse", 32'(bus.done0), 32'd0);

    // Simultaneous requests right after reset: port 0 first
    do_reset();
    bus.req0 = 1; bus.op0 = 4'd2; bus.a0 = 8'h0F; bus.b0 = 8'hF0;
    bus.req1 = 1; bus.op1 = 4'd3; bus.a1 = 8'h0F; bus.b1 = 8'hF0;
    tick();
    bus.req0 = 0;
    check("both_sel0", 32'(bus.alu_select), 32'd2);
    wait_done("both_p0", 1'b0, n);
    check("both_res0", 32'(bus.result0), 32'h00);
    check("both_zero0", 32'(bus.zero0), 32'd1);
    check("both_no_done1", 32'(bus.done1), 32'd0);
    tick();
    tick();
    bus.req1 = 0;
    check("both_sel1", 32'(bus.alu_select), 32'd3);
    wait_done("both_p1", 1'b1, n);
    check("both_res1", 32'(bus.result1), 32'hFF);
    check("both_zero1", 32'(bus.zero1), 32'd0);
    tick();

    // Continuous requests alternate 0,1,0,1
    bus.op0 = 4'd0; bus.b0 = 8'd1; bus.req0 = 1;
    bus.op1 = 4'd0; bus.b1 = 8'd2; bus.req1 = 1;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
          n = i;
          break;
        end
      end
      check("alt_seen", 32'(n != 0), 32'd1);
      p = bus.done1;
      check("alt_port", 32'(p), 32'(k % 2));
      check("alt_res", 32'(p ? bus.result1 : bus.result0), 32'(k + 1));
      if (k > 0) check("alt_spacing", 32'(cyc - last_cyc), 32'(LAT_BASIC + 2));
      last_cyc = cyc;
      if (p) bus.b1 = 8'(k + 3);
      else   bus.b0 = 8'(k + 3);
      tick();
      check("alt_pulse", 32'({bus.done0, bus.done1}), 32'd0);
    end
    bus.req0 = 0; bus.req1 = 0;
    tick();

    // Mult on port 1, then sll
    bus.req1 = 1; bus.op1 = 4'd8; bus.a1 = 8'd3; bus.b1 = 8'd4;
    tick();
    bus.req1 = 0;
    check("mul_sel", 32'(bus.alu_select), 32'd8);
    wait_done("mul", 1'b1, n);
    check("mul_lat", 32'(n), 32'(LAT_MULT));
    check("mul_res1", 32'(bus.result1), 32'd12);
    tick();
    bus.req1 = 1; bus.op1 = 4'd4; bus.a1 = 8'h81; bus.b1 = 8'd1;
    tick();
    bus.req1 = 0;
    wait_done("sll", 1'b1, n);
    check("sll_res1", 32'(bus.result1), 32'h02);
    tick();

    // Illegal op on port 0
    bus.req0 = 1; bus.op0 = 4'b1010; bus.a0 = 8'd9; bus.b0 = 8'd9;
    tick();
    bus.req0 = 0;
    check("ill_done0", 32'(bus.done0), 32'd1);
    check("ill_flag0", 32'(bus.illegal0), 32'd1);
    check("ill_sel_kept", 32'(bus.alu_select), 32'd4);
    check("ill_res_kept", 32'(bus.result0), 32'd3);
    tick();
    check("ill_pulse", 32'(bus.done0), 32'd0);
    bus.req0 = 1; bus.op0 = 4'd1; bus.a0 = 8'd1; bus.b0 = 8'd1;
    tick();
    bus.req0 = 0;
    wait_done("ill_clr", 1'b0, n);
    check("ill_clr_res", 32'(bus.result0), 32'd2);
    check("ill_clr_flag", 32'(bus.illegal0), 32'd0);
    tick();

    // Reset in the middle of a port-0 mult
    bus.req0 = 1; bus.op0 = 4'd8; bus.a0 = 8'd2; bus.b0 = 8'd5;
    tick();
    bus.req0 = 0;
    check("rb_sel", 32'(bus.alu_select), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    check("rb_sel0", 32'(bus.alu_select), 32'd0);
    check("rb_res0", 32'(bus.result0), 32'd0);
    check("rb_data1", 32'(bus.alu_data1), 32'd0);
    check("rb_done", 32'({bus.done0, bus.done1}), 32'd0);
    #4 rst_n = 1'b1;
    bus.req1 = 1; bus.op1 = 4'd1; bus.a1 = 8'd7; bus.b1 = 8'd9;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) bus.req1 = 0;
      check("rb_no_done0", 32'(bus.done0), 32'd0);
      if (bus.done1 === 1'b1) begin
        n = i;
        break;
      end
    end
    check("rb_done1_seen", 32'(n != 0), 32'd1);
    check("rb_res1", 32'(bus.result1), 32'd16);
    check("rb_res0_clear", 32'(bus.result0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
